sc_bit_pattern_matcher: RTL
===========================

SC_BIT_PATTERN_MATCHER -- requirements
Module: sc_bit_pattern_matcher

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8: match-counter width in bits.
REQ-003 SHALL have port SC_BitPatternMatcher_CLOCK_50, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port SC_BitPatternMatcher_RESET_InLow, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port SC_BitPatternMatcher_bit_In, input, 1 bit: serial data bit.
REQ-006 SHALL have port SC_BitPatternMatcher_valid_In, input, 1 bit: bit_In is sampled in cycles where this is high.
REQ-007 SHALL have port SC_BitPatternMatcher_pattern_In, input, WIDTH bits: reference pattern.
REQ-008 SHALL have port SC_BitPatternMatcher_mask_In, input, WIDTH bits: 1 = don't-care bit.
REQ-009 SHALL have port SC_BitPatternMatcher_load_In, input, 1 bit: one-cycle strobe that latches pattern_In and mask_In.
REQ-010 SHALL have port SC_BitPatternMatcher_match_Out, output, 1 bit: one-cycle match pulse.
REQ-011 SHALL have port SC_BitPatternMatcher_count_Out, output, CNT_W bits: saturating match count.
REQ-012 SHALL have port SC_BitPatternMatcher_armed_Out, output, 1 bit: high while state = ARMED.

Function
REQ-013 SHALL implement a three-state FSM (IDLE, FILL, ARMED), with next state and outputs registered.
REQ-014 In IDLE, SHALL ignore valid_In; load_In SHALL latch the pattern and mask, clear the shift register and fill counter, and move to FILL.
REQ-015 On each cycle with valid_In high and load_In low in FILL or ARMED, SHALL shift: sr <= {sr[WIDTH-2:0], bit_In}, with the newest bit at LSB; the first bit received therefore aligns to pattern MSB.
REQ-016 In FILL, SHALL increment the fill counter on each shift and move to ARMED on the shift that makes the count WIDTH, evaluating a compare on that same shift.
REQ-017 Per bit i, SHALL compute eq[i] = XNOR(next_sr[i], pattern[i]) OR mask[i]; a hit is the AND of all eq bits, evaluated on the post-shift value.
REQ-018 SHALL assert match_Out exactly one cycle after the valid cycle that completes a hit, for one cycle only; with no shift, match_Out SHALL be 0.
REQ-019 SHALL count overlapping matches; every shift in ARMED is a fresh compare.
REQ-020 SHALL increment count_Out on each match_Out pulse and hold it at 2^CNT_W-1 (saturate, no wrap).
REQ-021 load_In in FILL or ARMED SHALL re-latch the pattern and mask, clear sr, the fill counter and count_Out, and go to FILL; load_In wins over a simultaneous valid_In, and that bit is discarded with no match.
REQ-022 A match pending from the previous cycle SHALL still pulse during a load cycle, but SHALL NOT increment the cleared count.
REQ-023 With an all-ones mask, SHALL match on every shift once ARMED, including the shift that enters ARMED.
REQ-024 Gaps in valid_In SHALL NOT disturb sr, the fill counter or the state.

Reset
REQ-025 Asserting reset at any time, including mid-fill or mid-match, SHALL immediately force state IDLE, sr=0, pattern=0, mask=0, fill counter=0, match_Out=0, count_Out=0 and armed_Out=0.
REQ-026 Release of reset SHALL be synchronised to the clock edge; the first load_In is accepted in the first cycle after release.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE/FILL/ARMED) and the WIDTH/CNT_W defaults.
REQ-028 The per-bit compare SHALL be WIDTH generate-instantiated copies of the existing two-input XNOR gate cell, CC_GateXNOR; no other sub-module is used.

Verification
REQ-029 Reset test: assert reset mid-stream in ARMED with count=3 -> all outputs 0 in the same cycle, and state IDLE after release.
REQ-030 Basic match test: load pattern 8'hA5 with mask 0, then send 1,0,1,0,0,1,0,1 on consecutive valids -> armed_Out high after the 8th bit, match_Out one pulse the next cycle, count_Out=1.
REQ-031 Overlap and mask test: pattern 8'hFF, mask 0, send 10 ones -> 3 pulses and count=3; then reload with mask 8'hF0 and pattern 8'h0F, send 0000 1111 -> 1 match.
REQ-032 Load-versus-valid collision: load_In and valid_In both high -> bit discarded, fill restarts at 0, and 8 more bits are needed before armed_Out.
REQ-033 Saturation test: CNT_W=8, mask 8'hFF, 300 valid bits -> count_Out stops at 255, and match_Out continues pulsing.

Source files
------------

// File: rtl/sc_bit_pattern_matcher_pkg.sv
// Shared types and defaults for the serial bit-pattern matcher.
// Holds the FSM state encoding and the default pattern and counter widths.
// Imported by the top level and by the bench.
package sc_bit_pattern_matcher_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

endpackage : sc_bit_pattern_matcher_pkg

// File: rtl/sc_bit_pattern_matcher_xnor.sv
// Two-input XNOR gate cell used for the per-bit pattern compare.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake of any kind.
module CC_GateXNOR (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = ~(a_i ^ b_i);

endmodule : CC_GateXNOR

// File: rtl/sc_bit_pattern_matcher.sv
// Serial bit-pattern matcher with don't-care mask and saturating hit counter.
// Latency: match_Out pulses one cycle after the valid bit that completes a hit.
// Backpressure: none; a bit is taken on every valid cycle, load_In has priority.
module sc_bit_pattern_matcher
  import sc_bit_pattern_matcher_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             SC_BitPatternMatcher_CLOCK_50,
  input  logic             SC_BitPatternMatcher_RESET_InLow,
  input  logic             SC_BitPatternMatcher_bit_In,
  input  logic             SC_BitPatternMatcher_valid_In,
  input  logic [WIDTH-1:0] SC_BitPatternMatcher_pattern_In,
  input  logic [WIDTH-1:0] SC_BitPatternMatcher_mask_In,
  input  logic             SC_BitPatternMatcher_load_In,
  output logic             SC_BitPatternMatcher_match_Out,
  output logic [CNT_W-1:0] SC_BitPatternMatcher_count_Out,
  output logic             SC_BitPatternMatcher_armed_Out
);

  // Fill counter must be able to hold the value WIDTH itself.
  localparam int                FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               armed_q, armed_d;

  logic [WIDTH-1:0]   next_sr;
  logic [WIDTH-1:0]   eq;
  logic               hit;
  logic               shift;
  logic               cmp_en;

  // Compare is always done against the post-shift register contents.
  assign next_sr = {sr_q[WIDTH-2:0], SC_BitPatternMatcher_bit_In};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cmp
    logic xnor_y;
    CC_GateXNOR u_xnor (
      .a_i (next_sr[i]),
      .b_i (pat_q[i]),
      .y_o (xnor_y)
    );
    assign eq[i] = xnor_y | mask_q[i];
  end

  assign hit = &eq;

  // Next-state logic: load has priority, then shift on valid; IDLE ignores valid.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    fill_d  = fill_q;
    count_d = count_q;
    shift   = 1'b0;
    cmp_en  = 1'b0;

    case (state_q)
      ST_IDLE, ST_FILL, ST_ARMED: begin
        if (SC_BitPatternMatcher_load_In) begin
          pat_d   = SC_BitPatternMatcher_pattern_In;
          mask_d  = SC_BitPatternMatcher_mask_In;
          sr_d    = '0;
          fill_d  = '0;
          count_d = '0;
          state_d = ST_FILL;
        end else if (SC_BitPatternMatcher_valid_In && (state_q != ST_IDLE)) begin
          shift = 1'b1;
          sr_d  = next_sr;
          if (state_q == ST_FILL) begin
            fill_d = fill_q + 1'b1;
            // The shift that completes the fill is also the first compare.
            if (fill_q == FILL_LAST) begin
              state_d = ST_ARMED;
              cmp_en  = 1'b1;
            end
          end else begin
            cmp_en = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    match_d = shift & cmp_en & hit;
    // Count rises together with the match pulse and sticks at all-ones.
    if (match_d && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
    armed_d = (state_d == ST_ARMED);
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge SC_BitPatternMatcher_CLOCK_50 or negedge SC_BitPatternMatcher_RESET_InLow) begin
    if (!SC_BitPatternMatcher_RESET_InLow) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      pat_q   <= '0;
      mask_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      count_q <= count_d;
      armed_q <= armed_d;
    end
  end

  assign SC_BitPatternMatcher_match_Out = match_q;
  assign SC_BitPatternMatcher_count_Out = count_q;
  assign SC_BitPatternMatcher_armed_Out = armed_q;

endmodule : sc_bit_pattern_matcher
